// File: rtl/router_fsm_ctrl.sv
// Packet-reception sequencer for the 1x3 router: decodes the destination, stalls the source
// and sequences header/payload/parity writes. Optional macro ROUTER_FSM_DROP_EN adds a drop state for address 2'b11.
module router_fsm_ctrl #(
  parameter int ADDR_W = 2,
  parameter int ONEHOT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

`ifdef ROUTER_FSM_DROP_EN
  localparam int NST = 9;
`else
  localparam int NST = 8;
`endif
  localparam int SW = (ONEHOT != 0) ? NST : $clog2(NST);

  typedef enum logic [SW-1:0] {
    DECODE_ADDRESS     = SW'((ONEHOT != 0) ? (1 << 0) : 0),
    WAIT_TILL_EMPTY    = SW'((ONEHOT != 0) ? (1 << 1) : 1),
    LOAD_FIRST_DATA    = SW'((ONEHOT != 0) ? (1 << 2) : 2),
    LOAD_DATA          = SW'((ONEHOT != 0) ? (1 << 3) : 3),
    FIFO_FULL_STATE    = SW'((ONEHOT != 0) ? (1 << 4) : 4),
    LOAD_AFTER_FULL    = SW'((ONEHOT != 0) ? (1 << 5) : 5),
    LOAD_PARITY        = SW'((ONEHOT != 0) ? (1 << 6) : 6),
    CHECK_PARITY_ERROR = SW'((ONEHOT != 0) ? (1 << 7) : 7)
`ifdef ROUTER_FSM_DROP_EN
    , DROP_PACKET      = SW'((ONEHOT != 0) ? (1 << 8) : 8)
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [1:0]  sel_addr;
  logic [3:0]  empty_vec, soft_vec;
  logic        empty_sel, soft_sel, addr_ok;
  logic [7:0]  outs_d;

  assign addr_ok   = (data_in != 2'b11);
  assign sel_addr  = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
  assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign empty_sel = empty_vec[sel_addr];
  assign soft_sel  = soft_vec[addr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && addr_ok) begin
          addr_d  = data_in;
          state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
`ifdef ROUTER_FSM_DROP_EN
        else if (pkt_valid) begin
          state_d = DROP_PACKET;
        end
`endif
      end
      WAIT_TILL_EMPTY:    if (empty_sel) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`ifdef ROUTER_FSM_DROP_EN
      DROP_PACKET:        if (!pkt_valid) state_d = DECODE_ADDRESS;
`endif
      default:            state_d = DECODE_ADDRESS;
    endcase
    // An abort only matters for the latched port, and never while dropping.
    if (soft_sel && state_q != DECODE_ADDRESS
`ifdef ROUTER_FSM_DROP_EN
        && state_q != DROP_PACKET
`endif
       ) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  // Bit order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
  always_comb begin
    outs_d = 8'b0;
    unique case (state_d)
      DECODE_ADDRESS:     outs_d = 8'b1000_0000;
      WAIT_TILL_EMPTY:    outs_d = 8'b0000_0001;
      LOAD_FIRST_DATA:    outs_d = 8'b0100_0001;
      LOAD_DATA:          outs_d = 8'b0010_0100;
      FIFO_FULL_STATE:    outs_d = 8'b0000_1001;
      LOAD_AFTER_FULL:    outs_d = 8'b0001_0101;
      LOAD_PARITY:        outs_d = 8'b0000_0101;
      CHECK_PARITY_ERROR: outs_d = 8'b0000_0011;
      default:            outs_d = 8'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
      {detect_add, lfd_state, ld_state, laf_state,
       full_state, write_enb_reg, rst_int_reg, busy} <= 8'b1000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      {detect_add, lfd_state, ld_state, laf_state,
       full_state, write_enb_reg, rst_int_reg, busy} <= outs_d;
    end
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed-vector bench for router_fsm_ctrl; checks the packed output flags after each clock edge.
module tb_router_fsm_ctrl;
  logic clock = 1'b0;
  logic reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy;

  int checks = 0;
  int failures = 0;

  // Expected flag patterns: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
  localparam logic [7:0] E_DEC  = 8'b1000_0000;
  localparam logic [7:0] E_WAIT = 8'b0000_0001;
  localparam logic [7:0] E_LFD  = 8'b0100_0001;
  localparam logic [7:0] E_LD   = 8'b0010_0100;
  localparam logic [7:0] E_FULL = 8'b0000_1001;
  localparam logic [7:0] E_LAF  = 8'b0001_0101;
  localparam logic [7:0] E_LP   = 8'b0000_0101;
  localparam logic [7:0] E_CPE  = 8'b0000_0011;
  localparam logic [7:0] E_DROP = 8'b0000_0000;

  router_fsm_ctrl dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] flags();
    return {detect_add, lfd_state, ld_state, laf_state,
            full_state, write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic check_flags(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: flags %b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] exp);
    tick();
    check_flags(tag, flags(), exp);
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    tick(); tick();
    check_flags("reset", flags(), E_DEC);
    reset = 1'b0;
    step("idle_dec", E_DEC);

    // Normal packet to port 1 with four payload bytes.
    pkt_valid = 1'b1; data_in = 2'b01;
    step("norm_lfd", E_LFD);
    for (int i = 0; i < 4; i++) step($sformatf("norm_ld%0d", i), E_LD);
    pkt_valid = 1'b0;
    step("norm_lp", E_LP);
    step("norm_cpe", E_CPE);
    step("norm_dec", E_DEC);

    // Port 2 not empty: five wait cycles, then header once it drains.
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) step($sformatf("wait%0d", i), E_WAIT);
    fifo_empty_2 = 1'b1;
    step("wait_lfd", E_LFD);
    step("bp_ld", E_LD);

    // Back-pressure for three cycles, then load-after-full back to LOAD_DATA.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("bp_full%0d", i), E_FULL);
    fifo_full = 1'b0;
    step("bp_laf", E_LAF);
    step("bp_ld_again", E_LD);
    fifo_full = 1'b1;
    step("bp_full_b", E_FULL);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step("bp_laf_b", E_LAF);
    step("laf_low_lp", E_LP);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b1;
    step("cpe_full", E_CPE);
    step("cpe_to_full", E_FULL);
    fifo_full = 1'b0; parity_done = 1'b1;
    step("laf_pd", E_LAF);
    step("laf_pd_dec", E_DEC);
    parity_done = 1'b0;

    // Abort on port 0; a soft reset on port 1 must be ignored.
    pkt_valid = 1'b1; data_in = 2'b00;
    step("ab_lfd", E_LFD);
    step("ab_ld", E_LD);
    fifo_full = 1'b1;
    step("ab_full", E_FULL);
    soft_reset_1 = 1'b1;
    step("ab_sr1_ignored", E_FULL);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step("ab_sr0_dec", E_DEC);
    soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
    step("ab_idle", E_DEC);

    // DECODE must use data_in's empty flag, not the stale latched port 0.
    fifo_empty_1 = 1'b0; pkt_valid = 1'b1; data_in = 2'b01;
    step("dec_sel_wait", E_WAIT);
    soft_reset_1 = 1'b1;
    step("wait_sr1_dec", E_DEC);
    soft_reset_1 = 1'b0; pkt_valid = 1'b0; fifo_empty_1 = 1'b1;
    step("sr_idle", E_DEC);

    // Invalid address 2'b11 for three cycles.
    pkt_valid = 1'b1; data_in = 2'b11;
`ifdef ROUTER_FSM_DROP_EN
    for (int i = 0; i < 3; i++) step($sformatf("inv_drop%0d", i), E_DROP);
`else
    for (int i = 0; i < 3; i++) step($sformatf("inv_dec%0d", i), E_DEC);
`endif
    pkt_valid = 1'b0;
    step("inv_back_dec", E_DEC);

    // Reset in the middle of a packet.
    pkt_valid = 1'b1; data_in = 2'b10;
    step("mid_lfd", E_LFD);
    reset = 1'b1;
    step("mid_reset", E_DEC);
    reset = 1'b0; pkt_valid = 1'b0;
    step("post_reset", E_DEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
